// File: rtl/ravenoc_pkg.sv
// Shared NoC types: flit encodings, head-flit layout and the AXI-to-packetiser
// beat handshake structures.
package ravenoc_pkg;

    localparam int FLIT_DATA_WIDTH = 32;
    localparam int FLIT_TP_WIDTH   = 2;
    localparam int N_VIRT_CHN      = 3;
    localparam int VC_WIDTH        = $clog2(N_VIRT_CHN);
    localparam int X_WIDTH         = 2;
    localparam int Y_WIDTH         = 2;
    localparam int PKT_WIDTH       = 8;
    localparam int HEAD_DATA_WIDTH = FLIT_DATA_WIDTH - X_WIDTH - Y_WIDTH - PKT_WIDTH;

    typedef enum logic [FLIT_TP_WIDTH-1:0] {
        HEAD_FLIT      = 2'b00,
        BODY_FLIT      = 2'b01,
        TAIL_FLIT      = 2'b10,
        HEAD_TAIL_FLIT = 2'b11
    } flit_type_t;

    typedef struct packed {
        logic [X_WIDTH-1:0]         x_dest;
        logic [Y_WIDTH-1:0]         y_dest;
        logic [PKT_WIDTH-1:0]       pkt_size;
        logic [HEAD_DATA_WIDTH-1:0] data;
    } s_flit_head_data_t;

    typedef struct packed {
        logic                       valid;
        logic [VC_WIDTH-1:0]        vc_id;
        logic                       req_new;
        logic                       req_last;
        logic [PKT_WIDTH-1:0]       pkt_sz;
        logic [FLIT_DATA_WIDTH-1:0] flit_data_width;
    } s_pkt_out_req_t;

    typedef struct packed {
        logic ready;
    } s_pkt_out_resp_t;

endpackage

// File: rtl/flit_out_reg.sv
// One-entry valid/ready output register towards the router; the downstream
// ready is selected by the VC of the flit currently held.
module flit_out_reg #(
    parameter int FLIT_WIDTH = ravenoc_pkg::FLIT_TP_WIDTH + ravenoc_pkg::FLIT_DATA_WIDTH,
    parameter int N_VIRT_CHN = ravenoc_pkg::N_VIRT_CHN,
    parameter int VC_WIDTH   = ravenoc_pkg::VC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [FLIT_WIDTH-1:0] flit_i,
    input  logic [VC_WIDTH-1:0]   vc_i,
    input  logic [N_VIRT_CHN-1:0] ready_i,
    output logic [FLIT_WIDTH-1:0] flit_o,
    output logic [VC_WIDTH-1:0]   vc_o,
    output logic                  valid_o,
    output logic                  out_ok_o
);

    logic [FLIT_WIDTH-1:0] flit_q, flit_d;
    logic [VC_WIDTH-1:0]   vc_q, vc_d;
    logic                  valid_q, valid_d;
    logic                  taken;

    assign taken    = valid_q & ready_i[vc_q];
    assign out_ok_o = ~valid_q | ready_i[vc_q];

    // A load in the same cycle as a take replaces the entry without a bubble.
    always_comb begin
        flit_d  = flit_q;
        vc_d    = vc_q;
        valid_d = valid_q & ~taken;
        if (load_i) begin
            flit_d  = flit_i;
            vc_d    = vc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flit_q  <= '0;
            vc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            flit_q  <= flit_d;
            vc_q    <= vc_d;
            valid_q <= valid_d;
        end
    end

    assign flit_o  = flit_q;
    assign vc_o    = vc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pkt_gen.sv
// Packetiser: turns the AXI write-beat stream into HEAD/BODY/TAIL NoC flits,
// checking the beat count against req_last and draining over-long packets.
module pkt_gen #(
    parameter int FLIT_DATA_WIDTH = ravenoc_pkg::FLIT_DATA_WIDTH,
    parameter int FLIT_TP_WIDTH   = ravenoc_pkg::FLIT_TP_WIDTH,
    parameter int N_VIRT_CHN      = ravenoc_pkg::N_VIRT_CHN,
    parameter int VC_WIDTH        = $clog2(N_VIRT_CHN),
    parameter int X_WIDTH         = ravenoc_pkg::X_WIDTH,
    parameter int Y_WIDTH         = ravenoc_pkg::Y_WIDTH,
    parameter int PKT_WIDTH       = ravenoc_pkg::PKT_WIDTH
) (
    input  logic                                     clk_axi,
    input  logic                                     rst_axi_n,
    input  ravenoc_pkg::s_pkt_out_req_t              pkt_out_req,
    output ravenoc_pkg::s_pkt_out_resp_t             pkt_out_resp,
    output logic [FLIT_TP_WIDTH+FLIT_DATA_WIDTH-1:0] flit_o,
    output logic [VC_WIDTH-1:0]                      flit_vc_o,
    output logic                                     flit_valid_o,
    input  logic [N_VIRT_CHN-1:0]                    flit_ready_i,
    output logic                                     pkt_err_o
);

    import ravenoc_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam logic [PKT_WIDTH:0] REM_ONE = 1;

    state_t                     state_q, state_d;
    logic [PKT_WIDTH:0]         rem_q, rem_d;
    logic [VC_WIDTH-1:0]        vc_lock_q, vc_lock_d;
    logic                       pkt_err_q, pkt_err_d;

    logic                       out_ok;
    logic                       accept;
    logic                       load;
    flit_type_t                 flit_type;
    logic [FLIT_DATA_WIDTH-1:0] load_data;
    logic [FLIT_DATA_WIDTH-1:0] head_data;
    logic [VC_WIDTH-1:0]        load_vc;
    logic [PKT_WIDTH:0]         first_rem;
    logic                       unused_req_new;

    assign unused_req_new = pkt_out_req.req_new;

    assign pkt_out_resp.ready = rst_axi_n & ((state_q == ST_DRAIN) | out_ok);
    assign accept             = pkt_out_req.valid & pkt_out_resp.ready;

    // pkt_sz of zero encodes a full 2**PKT_WIDTH-beat packet.
    assign first_rem = (pkt_out_req.pkt_sz == '0) ? {1'b0, {PKT_WIDTH{1'b1}}}
                                                  : {1'b0, pkt_out_req.pkt_sz} - REM_ONE;

    assign head_data = {pkt_out_req.flit_data_width[FLIT_DATA_WIDTH-1 -: X_WIDTH+Y_WIDTH],
                        pkt_out_req.pkt_sz,
                        pkt_out_req.flit_data_width[FLIT_DATA_WIDTH-X_WIDTH-Y_WIDTH-PKT_WIDTH-1:0]};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        vc_lock_d = vc_lock_q;
        pkt_err_d = 1'b0;
        load      = 1'b0;
        flit_type = BODY_FLIT;
        load_data = pkt_out_req.flit_data_width;
        load_vc   = vc_lock_q;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    load      = 1'b1;
                    load_data = head_data;
                    load_vc   = pkt_out_req.vc_id;
                    vc_lock_d = pkt_out_req.vc_id;
                    rem_d     = first_rem;
                    if (first_rem == '0) begin
                        flit_type = HEAD_TAIL_FLIT;
                        if (!pkt_out_req.req_last) begin
                            pkt_err_d = 1'b1;
                            state_d   = ST_DRAIN;
                        end
                    end else if (pkt_out_req.req_last) begin
                        flit_type = HEAD_TAIL_FLIT;
                        pkt_err_d = 1'b1;
                    end else begin
                        flit_type = HEAD_FLIT;
                        state_d   = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    load      = 1'b1;
                    rem_d     = rem_q - REM_ONE;
                    flit_type = TAIL_FLIT;
                    if (rem_q == REM_ONE) begin
                        if (pkt_out_req.req_last) begin
                            state_d = ST_IDLE;
                        end else begin
                            pkt_err_d = 1'b1;
                            state_d   = ST_DRAIN;
                        end
                    end else if (pkt_out_req.req_last) begin
                        pkt_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        flit_type = BODY_FLIT;
                    end
                end
                ST_DRAIN: begin
                    if (pkt_out_req.req_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_axi) begin
        if (!rst_axi_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            vc_lock_q <= '0;
            pkt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            vc_lock_q <= vc_lock_d;
            pkt_err_q <= pkt_err_d;
        end
    end

    assign pkt_err_o = pkt_err_q;

    flit_out_reg #(
        .FLIT_WIDTH (FLIT_TP_WIDTH + FLIT_DATA_WIDTH),
        .N_VIRT_CHN (N_VIRT_CHN),
        .VC_WIDTH   (VC_WIDTH)
    ) u_flit_out_reg (
        .clk      (clk_axi),
        .rst_n    (rst_axi_n),
        .load_i   (load),
        .flit_i   ({flit_type, load_data}),
        .vc_i     (load_vc),
        .ready_i  (flit_ready_i),
        .flit_o   (flit_o),
        .vc_o     (flit_vc_o),
        .valid_o  (flit_valid_o),
        .out_ok_o (out_ok)
    );

endmodule
